mux_nx1_rr: RTL and testbench
=============================

Name: mux_nx1_rr

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Two select modes: manual, where the `sel` port chooses the channel, and round-robin arbitration across valid channels.
- Successor to the combinational 4-bit 2:1/4:1/8:1 mux tree; used wherever several producers share one consumer path.
- One-entry output register: 1-cycle latency, full throughput of 1 transfer/cycle.

Parameters:
- N, 8, number of input channels; N >= 2.
- WIDTH, 4, data width per channel.
- SELW, 3, width of `sel` and `out_ch`; must satisfy 2^SELW >= N.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = manual (`sel`), 1 = round-robin.
- sel  input  SELW  channel index used in manual mode.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered; output register holds data.
- out_ready  input  1  consumer accepts `out_data` this cycle.
- out_ch  output  SELW  registered index of the channel that produced `out_data`.

Behaviour:
- Reset (asynchronous, immediate on assertion): out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0. While reset is high, in_ready=0.
- Reset mid-operation: any held output word is discarded and no handshake completes. After release, the first grant in round-robin mode searches from channel 0.
- load_ok = !out_valid || out_ready. The output slot is free, or is being emptied in the same cycle.
- Grant selection (combinational, every cycle):
  - Manual mode: grant = sel, only if sel < N and in_valid[sel]=1. If sel >= N, there is no grant and all in_ready are 0.
  - Round-robin mode: grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N). No valid input means no grant.
- in_ready[i] = load_ok && grant exists && grant==i. At most one bit is set. in_ready must not depend on in_valid of any channel other than through grant selection.
- Transfer occurs when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - ptr <= (g==N-1) ? 0 : g+1. ptr updates in both modes.
- No transfer and out_ready=1: out_valid <= 0; out_data and out_ch hold their last values.
- No transfer and out_ready=0: all registers hold. Data under backpressure must remain stable.
- Simultaneous output drain and new transfer in the same cycle: the new word replaces the old one, out_valid stays 1, no bubble.
- Latency: input transfer at edge k appears on out_data/out_valid after edge k and is consumable from cycle k+1.
- Mode or sel changes take effect in the same cycle with no state flush. ptr is preserved across mode changes.
- ptr wrap-around: a grant to channel N-1 sets ptr=0.
- Arithmetic: ptr and the channel index are SELW bits. Comparisons against N are unsigned.

Test Plan:
- Reset: assert reset mid-cycle with out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately, in_ready=0. Release, then mode=1 with all 8 channels valid -> channel 0 is granted first.
- Manual select: mode=0, sel=5, in_valid=8'hFF, channel 5 data=4'hA, out_ready=1 -> in_ready=8'h20. Next cycle out_data=4'hA, out_ch=5, out_valid=1.
- Round-robin with wrap: mode=1, in_valid=8'hFF, channel i data=i, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1; out_valid stays 1 with no bubbles.
- Sparse round-robin: mode=1, in_valid=8'b1001_0010 held, ptr=2 -> grants 4, 7, 1, 4 in that order.
- Backpressure: out_ready=0 for 3 cycles after a transfer of channel 3 (data 4'h6) -> in_ready=0. out_data=4'h6, out_ch=3 and out_valid=1 stay stable. Raising out_ready reloads in the same cycle.
- Out-of-range select: N=6, SELW=3, mode=0, sel=7, in_valid all 1 -> in_ready=0 for all channels. out_valid drains to 0 one cycle after out_ready=1.

Source files
------------

// File: rtl/mux_nx1_rr.sv
// N-channel registered multiplexer with valid/ready handshakes and a choice of
// manual (sel) or round-robin channel selection.
module mux_nx1_rr #(
    parameter int N     = 8,
    parameter int WIDTH = 4,
    parameter int SELW  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_ch
);

    localparam logic [SELW:0]   N_W  = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [SELW-1:0]  ptr_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic [SELW-1:0]  out_ch_r;

    logic             rr_found_s;
    logic [SELW-1:0]  rr_idx_s;
    logic             man_valid_s;
    logic             sel_in_range_s;
    logic             grant_valid_s;
    logic [SELW-1:0]  grant_s;
    logic             load_ok_s;
    logic             xfer_s;
    logic [WIDTH-1:0] grant_data_s;
    logic [SELW-1:0]  ptr_next_s;

    // Round-robin search: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i] && (SELW'(i) >= ptr_r)) begin
                rr_found_s = 1'b1;
                rr_idx_s   = SELW'(i);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
        if (!rr_found_s) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    rr_found_s = 1'b1;
                    rr_idx_s   = SELW'(i);
                end else begin
                    rr_found_s = rr_found_s;
                end
            end
        end else begin
            rr_idx_s = rr_idx_s;
        end
    end

    // Manual selection: sel must name an existing channel that is presenting data.
    always_comb begin
        man_valid_s    = 1'b0;
        sel_in_range_s = ({1'b0, sel} < N_W);
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                man_valid_s = in_valid[i];
            end else begin
                man_valid_s = man_valid_s;
            end
        end
    end

    // Grant, handshake and data steering.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = '0;
        grant_data_s  = '0;
        in_ready      = '0;
        if (mode) begin
            grant_valid_s = rr_found_s;
            grant_s       = rr_idx_s;
        end else begin
            grant_valid_s = sel_in_range_s && man_valid_s;
            grant_s       = sel;
        end
        load_ok_s = !out_valid_r || out_ready;
        xfer_s    = !reset && load_ok_s && grant_valid_s;
        for (int i = 0; i < N; i++) begin
            if (grant_s == SELW'(i)) begin
                grant_data_s = in_data[i*WIDTH +: WIDTH];
                in_ready[i]  = xfer_s;
            end else begin
                in_ready[i]  = 1'b0;
            end
        end
        if (grant_s == LAST) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_s + SELW'(1);
        end
    end

    // Output slot and round-robin pointer; a new word may replace one being drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            ptr_r       <= '0;
        end else if (xfer_s) begin
            out_data_r  <= grant_data_s;
            out_valid_r <= 1'b1;
            out_ch_r    <= grant_s;
            ptr_r       <= ptr_next_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: default 8-channel instance plus a 6-channel
// instance for out-of-range select.
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_ch;

    logic [23:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic        mode6;
    logic [2:0]  sel6;
    logic [3:0]  out_data6;
    logic        out_valid6;
    logic        out_ready6;
    logic [2:0]  out_ch6;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_nx1_rr #(.N(8), .WIDTH(4), .SELW(3)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    mux_nx1_rr #(.N(6), .WIDTH(4), .SELW(3)) dut6 (
        .clk(clk), .reset(reset), .in_data(in_data6), .in_valid(in_valid6),
        .in_ready(in_ready6), .mode(mode6), .sel(sel6), .out_data(out_data6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_ch(out_ch6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ident();
        for (int i = 0; i < 8; i++) in_data[i*4 +: 4] = 4'(i);
    endtask

    initial begin
        int exp_sparse [4] = '{4, 7, 1, 4};

        reset = 1'b1; mode = 1'b1; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b0;
        in_data = 32'h0; set_ident();
        in_data6 = 24'h0; in_valid6 = 6'h0; mode6 = 1'b0; sel6 = 3'd0; out_ready6 = 1'b0;
        step(); step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_ready", 32'(in_ready), 32'h0);

        // manual select of channel 5
        reset = 1'b0; mode = 1'b0; sel = 3'd5; in_data[20 +: 4] = 4'hA; out_ready = 1'b1;
        #1;
        check("man_ready", 32'(in_ready), 32'h20);
        step();
        check("man_data", 32'(out_data), 32'hA);
        check("man_ch", 32'(out_ch), 32'd5);
        check("man_valid", 32'(out_valid), 32'd1);

        // asynchronous reset with a held word
        #1 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_ch", 32'(out_ch), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'h0);
        reset = 1'b0; mode = 1'b1; set_ident();
        #1;
        check("rr_first_ready", 32'(in_ready), 32'h01);

        // full round-robin with wrap, no bubbles
        for (int k = 0; k < 10; k++) begin
            step();
            check("rr_ch", 32'(out_ch), 32'(k % 8));
            check("rr_data", 32'(out_data), 32'(k % 8));
            check("rr_valid", 32'(out_valid), 32'd1);
        end

        // sparse round-robin starting from ptr=2
        in_valid = 8'b1001_0010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("sparse_ch", 32'(out_ch), 32'(exp_sparse[k]));
            check("sparse_data", 32'(out_data), 32'(exp_sparse[k]));
        end

        // backpressure after a channel-3 transfer
        mode = 1'b0; sel = 3'd3; in_valid = 8'hFF; in_data[12 +: 4] = 4'h6;
        step();
        check("bp_load_ch", 32'(out_ch), 32'd3);
        check("bp_load_data", 32'(out_data), 32'h6);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 32'(in_ready), 32'h0);
            step();
            check("bp_data", 32'(out_data), 32'h6);
            check("bp_ch", 32'(out_ch), 32'd3);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        in_data[12 +: 4] = 4'h9; out_ready = 1'b1;
        #1;
        check("reload_ready", 32'(in_ready), 32'h08);
        step();
        check("reload_data", 32'(out_data), 32'h9);
        check("reload_valid", 32'(out_valid), 32'd1);

        // ptr (4) survives the switch to round-robin
        mode = 1'b1;
        #1;
        check("mode_sw_ready", 32'(in_ready), 32'h10);
        in_valid = 8'h00;
        #1;
        check("idle_ready", 32'(in_ready), 32'h0);
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data_hold", 32'(out_data), 32'h9);
        check("drain_ch_hold", 32'(out_ch), 32'd3);

        // out-of-range select on the 6-channel instance
        in_valid6 = 6'h3F; sel6 = 3'd2; in_data6[8 +: 4] = 4'hC; out_ready6 = 1'b1;
        step();
        check("n6_valid", 32'(out_valid6), 32'd1);
        check("n6_data", 32'(out_data6), 32'hC);
        check("n6_ch", 32'(out_ch6), 32'd2);
        sel6 = 3'd7;
        #1;
        check("n6_sel7_ready", 32'(in_ready6), 32'h0);
        step();
        check("n6_drain_valid", 32'(out_valid6), 32'd0);
        sel6 = 3'd6;
        #1;
        check("n6_sel6_ready", 32'(in_ready6), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
